slc_mem_ctrl: RTL

//  Parametrised SRAM + memory-mapped I/O controller for the SLC-3 core; next generation of the CPU/Mem2IO/tristate path.

---
 rtl/slc_mem_pkg.sv | 9 +
 rtl/sync_bus.sv | 23 ++
 rtl/slc_mem_ctrl.sv | 120 ++++++++++++
 3 files changed

// File: rtl/slc_mem_pkg.sv
// slc_mem_pkg: shared FSM states and defaults for the SLC-3 memory controller.
package slc_mem_pkg;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, DONE} state_e;

    localparam logic [15:0] DEF_SW_ADDR = 16'hFFFF;
    localparam int          CNT_W       = 4;

endpackage

// File: rtl/sync_bus.sv
// sync_bus: two-flop synchroniser for a multi-bit quasi-static bus.
module sync_bus #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d_i,
    output logic [W-1:0] q_o
);

    logic [W-1:0] meta_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            meta_q <= '0;
            q_o    <= '0;
        end else begin
            meta_q <= d_i;
            q_o    <= meta_q;
        end
    end

endmodule

// File: rtl/slc_mem_ctrl.sv
// slc_mem_ctrl: single-access SRAM controller with switch/hex I/O decode and
// ownership of the bidirectional SRAM data bus.
module slc_mem_ctrl
    import slc_mem_pkg::*;
#(
    parameter int                    DATA_W      = 16,
    parameter int                    CPU_ADDR_W  = 16,
    parameter int                    SRAM_ADDR_W = 20,
    parameter int                    WAIT_STATES = 2,
    parameter int                    NUM_HEX     = 4,
    parameter logic [CPU_ADDR_W-1:0] SW_ADDR     = CPU_ADDR_W'(DEF_SW_ADDR)
) (
    input  logic                   Clk,
    input  logic                   Reset_n,
    input  logic                   req,
    input  logic                   we,
    input  logic [DATA_W/8-1:0]    be,
    input  logic [CPU_ADDR_W-1:0]  addr,
    input  logic [DATA_W-1:0]      wdata,
    output logic                   ready,
    output logic [DATA_W-1:0]      rdata,
    input  logic [DATA_W-1:0]      Switches,
    output logic [4*NUM_HEX-1:0]   hex_digits,
    output logic                   CE,
    output logic                   OE,
    output logic                   WE,
    output logic [DATA_W/8-1:0]    BE_n,
    output logic [SRAM_ADDR_W-1:0] ADDR,
    inout  wire  [DATA_W-1:0]      Data
);

    localparam int NB = DATA_W / 8;
    localparam int HW = 4 * NUM_HEX;

    state_e                  state_q, state_d;
    logic                    we_q;
    logic [NB-1:0]           be_q;
    logic [CPU_ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]       wdata_q;
    logic [CNT_W-1:0]        cnt_q;
    logic [DATA_W-1:0]       rdata_q;
    logic [HW-1:0]           hex_q;
    logic [HW-1:0]           hex_msk;
    logic [DATA_W-1:0]       sw_sync;
    logic                    sram_act;
    logic                    drive;

    sync_bus #(.W(DATA_W)) u_sync (
        .clk   (Clk),
        .rst_n (Reset_n),
        .d_i   (Switches),
        .q_o   (sw_sync)
    );

    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // SRAM strobes stay asserted through DONE so write data/address are held
    // past the WE rising edge; the I/O path never touches the SRAM.
    always_comb begin
        state_d  = state_q;
        sram_act = (state_q != IDLE) && (addr_q != SW_ADDR);
        CE       = !sram_act;
        OE       = !(state_q == ACCESS && !we_q);
        WE       = !(state_q == ACCESS && we_q);
        BE_n     = sram_act ? ~be_q : '1;
        drive    = sram_act && we_q;
        ready    = state_q == DONE;
        unique case (state_q)
            IDLE:    state_d = req ? ((addr == SW_ADDR) ? DONE : SETUP) : IDLE;
            SETUP:   state_d = ACCESS;
            ACCESS:  state_d = (cnt_q == '0) ? DONE : ACCESS;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        hex_msk = '0;
        for (int i = 0; i < HW; i++) hex_msk[i] = be[i/8];
    end

    // rdata and the hex register update on the edge entering DONE so both are
    // valid while ready is high.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            we_q    <= 1'b0;
            be_q    <= '0;
            addr_q  <= '0;
            wdata_q <= '0;
            cnt_q   <= '0;
            rdata_q <= '0;
            hex_q   <= '0;
        end else begin
            if (state_q == IDLE && req) begin
                we_q    <= we;
                be_q    <= be;
                addr_q  <= addr;
                wdata_q <= wdata;
                cnt_q   <= CNT_W'(WAIT_STATES);
                if (addr == SW_ADDR) begin
                    if (we)       hex_q   <= (hex_q & ~hex_msk) | (wdata[HW-1:0] & hex_msk);
                    else if (|be) rdata_q <= sw_sync;
                end
            end
            if (state_q == ACCESS) begin
                cnt_q <= cnt_q - 1'b1;
                if (cnt_q == '0 && !we_q && |be_q) rdata_q <= Data;
            end
        end
    end

    assign Data       = drive ? wdata_q : {DATA_W{1'bz}};
    assign ADDR       = SRAM_ADDR_W'(addr_q);
    assign rdata      = rdata_q;
    assign hex_digits = hex_q;

endmodule
